genius_input_checker: RTL and testbench

//  Player-side counterpart of the Genius sequence ROMs: reads the stored colour sequence back step by step.

---
 rtl/genius_pkg.sv | 24 ++
 rtl/genius_input_checker_if.sv | 40 ++++
 rtl/genius_press_detect.sv | 35 +++
 rtl/genius_input_checker.sv | 171 +++++++++++++++++
 tb/tb_genius_input_checker.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius player-input checker.
//   ADDR_W_DEF / COLOR_W_DEF : default address and colour widths
//   SEQ_LEN                  : longest round the sequence ROM can hold
//   state_t                  : checker FSM states (also exported on state_dbg)
//   RED/GRN/BLU/YEL          : one-hot colour codes, one bit per button
package genius_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int COLOR_W_DEF = 4;
  localparam int SEQ_LEN     = 16;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_REL     = 2'd2,
    ST_WAIT_REL_END = 2'd3
  } state_t;

  localparam logic [3:0] RED = 4'b0001;
  localparam logic [3:0] GRN = 4'b0010;
  localparam logic [3:0] BLU = 4'b0100;
  localparam logic [3:0] YEL = 4'b1000;

endpackage

// File: rtl/genius_input_checker_if.sv
// Signal bundle between the game controller / button block / sequence ROM
// (master side) and the input checker (slave side).
//   start, round_len : round launch (round_len sampled only with start)
//   btn              : debounced button levels
//   rom_addr/rom_data: combinational sequence ROM lookup
//   busy, step_ok, round_ok, mistake, timeout, progress : checker status
//
// Protocol: there is no valid/ready pair. start is a single-cycle request that
// the checker always accepts (round_len==0 excepted). step_ok, round_ok,
// mistake and timeout are single-cycle registered pulses with no back-pressure;
// the consumer must sample them on the cycle they are high. busy and progress
// are levels valid every cycle.
interface genius_input_checker_if #(
  parameter int ADDR_W  = 4,
  parameter int COLOR_W = 4
);

  logic                start;
  logic [ADDR_W:0]     round_len;
  logic [COLOR_W-1:0]  btn;
  logic [ADDR_W-1:0]   rom_addr;
  logic [COLOR_W-1:0]  rom_data;
  logic                busy;
  logic                step_ok;
  logic                round_ok;
  logic                mistake;
  logic                timeout;
  logic [ADDR_W-1:0]   progress;

  modport master (
    output start, round_len, btn, rom_data,
    input  rom_addr, busy, step_ok, round_ok, mistake, timeout, progress
  );

  modport slave (
    input  start, round_len, btn, rom_data,
    output rom_addr, busy, step_ok, round_ok, mistake, timeout, progress
  );

endinterface

// File: rtl/genius_press_detect.sv
// Button edge detector for the input checker.
//   clk, rst_n : clock, synchronous active-low reset
//   btn        : debounced button levels
//   press      : all buttons were released last cycle and some are down now
//   one_hot    : exactly one button is down this cycle
//   released   : no button is down this cycle
module genius_press_detect #(
  parameter int COLOR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] btn,
  output logic               press,
  output logic               one_hot,
  output logic               released
);

  logic [COLOR_W-1:0] btn_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn;
    end
  end

  // A press only counts coming out of the all-released condition, so adding a
  // second finger or sliding between buttons never produces a new event.
  assign released = (btn == '0);
  assign press    = (btn_q == '0) && !released;
  // Clearing the lowest set bit leaves zero only for a single set bit.
  assign one_hot  = !released && ((btn & (btn - COLOR_W'(1))) == '0);

endmodule

// File: rtl/genius_input_checker.sv
// Genius player-input checker: walks the stored colour sequence one step per
// press and compares each press with the ROM colour of the current step.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : genius_input_checker_if slave port (start/round_len/btn in,
//                rom_addr/rom_data ROM lookup, status pulses and levels out)
//   state_dbg  : current FSM state, for observation only
// Optional build macro GENIUS_TIMEOUT_EN adds an inactivity timer of
// TIMEOUT_CYC cycles in WAIT_PRESS; without it a round waits forever and
// timeout stays 0.
module genius_input_checker
  import genius_pkg::*;
#(
  parameter int          ADDR_W      = ADDR_W_DEF,
  parameter int          COLOR_W     = COLOR_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  genius_input_checker_if.slave  bus,
  output state_t                 state_dbg
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t              state, next_state;
  logic [ADDR_W-1:0]   idx, idx_nxt;
  logic [ADDR_W:0]     len, len_nxt;
  logic                step_ok_q, step_ok_nxt;
  logic                round_ok_q, round_ok_nxt;
  logic                mistake_q, mistake_nxt;
  logic                to_fire;      // this cycle's mistake is an inactivity expiry
  logic                enter_press;  // next state is a fresh WAIT_PRESS entry
  logic                to_expired;
  logic                press, one_hot, released;

  genius_press_detect #(.COLOR_W(COLOR_W)) u_press_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (bus.btn),
    .press    (press),
    .one_hot  (one_hot),
    .released (released)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      len        <= '0;
      step_ok_q  <= 1'b0;
      round_ok_q <= 1'b0;
      mistake_q  <= 1'b0;
    end else begin
      state      <= next_state;
      idx        <= idx_nxt;
      len        <= len_nxt;
      step_ok_q  <= step_ok_nxt;
      round_ok_q <= round_ok_nxt;
      mistake_q  <= mistake_nxt;
    end
  end

  always_comb begin
    next_state   = state;
    idx_nxt      = idx;
    len_nxt      = len;
    step_ok_nxt  = 1'b0;
    round_ok_nxt = 1'b0;
    mistake_nxt  = 1'b0;
    to_fire      = 1'b0;
    enter_press  = 1'b0;

    // start wins over everything, including a press on the same edge. A
    // start held with a button down waits for release so that press is not
    // counted as the first step.
    if (bus.start && (bus.round_len != '0)) begin
      idx_nxt = '0;
      len_nxt = (bus.round_len > MAX_LEN) ? MAX_LEN : bus.round_len;
      if (released) begin
        next_state  = ST_WAIT_PRESS;
        enter_press = 1'b1;
      end else begin
        next_state  = ST_WAIT_REL;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          next_state = ST_IDLE;
        end
        ST_WAIT_PRESS: begin
          // A press on the expiry cycle is judged normally; timeout only
          // fires when nothing was pressed.
          if (press) begin
            if (!one_hot || (bus.btn != bus.rom_data)) begin
              mistake_nxt = 1'b1;
              next_state  = ST_IDLE;
            end else if ({1'b0, idx} == (len - (ADDR_W+1)'(1))) begin
              round_ok_nxt = 1'b1;
              idx_nxt      = '0;
              next_state   = ST_WAIT_REL_END;
            end else begin
              step_ok_nxt = 1'b1;
              idx_nxt     = idx + ADDR_W'(1);
              next_state  = ST_WAIT_REL;
            end
          end else if (to_expired) begin
            mistake_nxt = 1'b1;
            to_fire     = 1'b1;
            next_state  = ST_IDLE;
          end
        end
        ST_WAIT_REL: begin
          if (released) begin
            next_state  = ST_WAIT_PRESS;
            enter_press = 1'b1;
          end
        end
        ST_WAIT_REL_END: begin
          if (released) begin
            next_state = ST_IDLE;
          end
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

`ifdef GENIUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] to_cnt;
  logic             timeout_q;

  // Reloaded on every entry to WAIT_PRESS, counts down only while waiting for
  // a press, and holds in every other state. Reaching zero in WAIT_PRESS is
  // the expiry, giving exactly TIMEOUT_CYC cycles of waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_fire;
      if (enter_press) begin
        to_cnt <= CNT_W'(TIMEOUT_CYC - 1);
      end else if ((state == ST_WAIT_PRESS) && (to_cnt != '0)) begin
        to_cnt <= to_cnt - CNT_W'(1);
      end
    end
  end

  assign to_expired  = (state == ST_WAIT_PRESS) && (to_cnt == '0);
  assign bus.timeout = timeout_q;
`else
  logic unused_to;

  assign to_expired  = 1'b0;
  assign bus.timeout = 1'b0;
  assign unused_to   = ^{TIMEOUT_CYC, to_fire, enter_press};
`endif

  assign bus.rom_addr = idx;
  assign bus.progress = idx;
  assign bus.busy     = (state == ST_WAIT_PRESS) || (state == ST_WAIT_REL);
  assign bus.step_ok  = step_ok_q;
  assign bus.round_ok = round_ok_q;
  assign bus.mistake  = mistake_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_genius_input_checker.sv
module tb_genius_input_checker;
  import genius_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  genius_input_checker_if #(.ADDR_W(4), .COLOR_W(4)) bus_if();
  state_t state_dbg;

  logic [3:0] rom [16];
  assign bus_if.rom_data = rom[bus_if.rom_addr];

  genius_input_checker #(
    .ADDR_W      (4),
    .COLOR_W     (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  // entry = {round_ok, step_ok, mistake, timeout, progress}
  logic [7:0] exp_q[$];
  int pass_cnt  = 0;
  int check_cnt = 0;

  // reference model of the round in progress
  int m_idx    = 0;
  int m_len    = 0;
  bit m_active = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (bus_if.step_ok || bus_if.round_ok || bus_if.mistake || bus_if.timeout) begin
      if (exp_q.size() == 0)
        chk("unexpected_pulse",
            {24'd0, bus_if.round_ok, bus_if.step_ok, bus_if.mistake, bus_if.timeout, bus_if.progress}, 32'd0);
      else
        chk("pulse",
            {24'd0, bus_if.round_ok, bus_if.step_ok, bus_if.mistake, bus_if.timeout, bus_if.progress},
            {24'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic start_round(input int len, input logic [3:0] b);
    bus_if.start     = 1'b1;
    bus_if.round_len = 5'(len);
    bus_if.btn       = b;
    @(negedge clk);
    bus_if.start = 1'b0;
    if (len != 0) begin
      m_idx    = 0;
      m_len    = (len > 16) ? 16 : len;
      m_active = (b == 4'b0000);
    end
  endtask

  task automatic press(input logic [3:0] color);
    if (m_active) begin
      if ($countones(color) != 1 || color != rom[m_idx]) begin
        exp_q.push_back({4'b0010, 4'(m_idx)});
        m_active = 0;
      end else if (m_idx == m_len - 1) begin
        exp_q.push_back({4'b1000, 4'd0});
        m_idx    = 0;
        m_active = 0;
      end else begin
        m_idx++;
        exp_q.push_back({4'b0100, 4'(m_idx)});
      end
    end
    bus_if.btn = color;
    @(negedge clk);
  endtask

  task automatic release_btn();
    bus_if.btn = 4'b0000;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int seen;
    for (int i = 0; i < 16; i++) rom[i] = 4'b0000;
    rst_n            = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.round_len = '0;
    bus_if.btn       = BLU;

    // 1. reset with a button held
    repeat (2) @(negedge clk);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_step_ok", bus_if.step_ok, 0);
    chk("rst_round_ok", bus_if.round_ok, 0);
    chk("rst_mistake", bus_if.mistake, 0);
    chk("rst_timeout", bus_if.timeout, 0);
    chk("rst_progress", bus_if.progress, 0);
    chk("rst_rom_addr", bus_if.rom_addr, 0);
    chk("rst_state", state_dbg, ST_IDLE);
    rst_n      = 1'b1;
    bus_if.btn = 4'b0000;
    @(negedge clk);

    // 2. correct three-step round
    rom[0] = RED; rom[1] = BLU; rom[2] = GRN;
    start_round(3, 4'b0000);
    chk("t2_busy", bus_if.busy, 1);
    chk("t2_state", state_dbg, ST_WAIT_PRESS);
    press(RED);  release_btn();
    chk("t2_rom_addr1", bus_if.rom_addr, 1);
    press(BLU);  release_btn();
    chk("t2_progress2", bus_if.progress, 2);
    press(GRN);
    chk("t2_busy_end", bus_if.busy, 0);
    chk("t2_state_end", state_dbg, ST_WAIT_REL_END);
    release_btn();
    chk("t2_idle", state_dbg, ST_IDLE);

    // 3. wrong colour at step 1
    start_round(3, 4'b0000);
    press(RED);  release_btn();
    press(YEL);
    chk("t3_busy", bus_if.busy, 0);
    chk("t3_state", state_dbg, ST_IDLE);
    release_btn();

    // 4. multi-button press, zero length, clamped length
    start_round(3, 4'b0000);
    press(4'b0011);
    chk("t4_multi_idle", state_dbg, ST_IDLE);
    release_btn();
    start_round(0, 4'b0000);
    chk("t4_len0_busy", bus_if.busy, 0);
    chk("t4_len0_state", state_dbg, ST_IDLE);
    for (int i = 0; i < 16; i++) rom[i] = 4'(1 << $urandom_range(0, 3));
    start_round(20, 4'b0000);
    for (int i = 0; i < 15; i++) begin
      press(rom[i]);
      release_btn();
    end
    chk("t4_progress15", bus_if.progress, 15);
    chk("t4_busy15", bus_if.busy, 1);
    press(rom[15]);
    release_btn();
    chk("t4_done", state_dbg, ST_IDLE);

    // 5. start on the same edge as a press, button held
    rom[0] = RED; rom[1] = BLU; rom[2] = GRN;
    start_round(3, RED);
    chk("t5_state", state_dbg, ST_WAIT_REL);
    chk("t5_progress", bus_if.progress, 0);
    repeat (2) @(negedge clk);
    chk("t5_hold", state_dbg, ST_WAIT_REL);
    release_btn();
    chk("t5_wait_press", state_dbg, ST_WAIT_PRESS);
    m_active = 1;
    press(RED);  release_btn();
    // restart mid-round
    start_round(2, 4'b0000);
    chk("t5_restart_progress", bus_if.progress, 0);
    chk("t5_restart_state", state_dbg, ST_WAIT_PRESS);
    press(RED);  release_btn();
    press(BLU);  release_btn();
    chk("t5_done", state_dbg, ST_IDLE);

    // 6. inactivity
    start_round(3, 4'b0000);
`ifdef GENIUS_TIMEOUT_EN
    exp_q.push_back({4'b0011, 4'd0});
    m_active = 0;
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus_if.mistake) begin
        seen = c;
        break;
      end
    end
    chk("t6_timeout_cycles", seen, 8);
    chk("t6_state", state_dbg, ST_IDLE);
`else
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus_if.timeout || bus_if.mistake) seen++;
    end
    chk("t6_no_timeout", seen, 0);
    chk("t6_still_waiting", state_dbg, ST_WAIT_PRESS);
    press(YEL);  release_btn();
`endif

    // 7. reset mid-round is silent
    start_round(3, 4'b0000);
    press(RED);  release_btn();
    rst_n = 1'b0;
    @(negedge clk);
    m_active = 0;
    chk("t7_busy", bus_if.busy, 0);
    chk("t7_progress", bus_if.progress, 0);
    chk("t7_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
